// File: rtl/falling_edge_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// axi_util_pkg
// Shared types and helpers for the AXI interconnect utility layer.
//   pulse_gen_state_e : state encoding of falling_edge_pulse_gen
//   cnt_w(n)          : bits needed to hold the values 0..n
// -----------------------------------------------------------------------------
package axi_util_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_gen_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/falling_edge_pulse_gen_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Down-counter used to time one phase of a shaped pulse. It is loaded on
// phase entry and counts down to zero, where it holds until the next load.
// Ports:
//   ACLK       : clock
//   ARESETN    : synchronous active-low reset
//   load       : load load_value (wins over enable)
//   load_value : phase length minus one
//   enable     : count down while non-zero
//   zero       : count has reached zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 2
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/falling_edge_pulse_gen.sv
// -----------------------------------------------------------------------------
// falling_edge_pulse_gen
// Turns single-cycle event requests into level pulses of HIGH_CYCLES high
// followed by at least LOW_CYCLES low, so a downstream falling-edge detector
// sees exactly one edge per accepted event. Requests arriving mid-pulse are
// queued in a saturating counter and replayed back-to-back.
// Ports:
//   ACLK          : clock
//   ARESETN       : synchronous active-low reset
//   Trigger       : single-cycle event request
//   Clear         : drop all queued requests (pulse in flight completes)
//   Level_Out     : shaped level, one falling edge per event
//   Done_Pulse    : one cycle, first low cycle after each pulse
//   Busy          : state is not IDLE
//   Pending_Count : queued requests
//   Overflow      : one cycle, a request was dropped on a full queue
// All outputs are registered.
// -----------------------------------------------------------------------------
module falling_edge_pulse_gen
    import axi_util_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               Trigger,
    input  logic                               Clear,
    output logic                               Level_Out,
    output logic                               Done_Pulse,
    output logic                               Busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   Pending_Count,
    output logic                               Overflow
);

    localparam int PW   = cnt_w(MAX_PENDING);
    localparam int TMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    // A one-cycle phase would give a zero-width timer; keep at least one bit.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    pulse_gen_state_e state, state_n;

    logic          timer_zero;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          done_n;
    logic          ovf_n;
    logic          do_inc;
    logic          do_dec;
    logic          pend_avail;
    logic [PW-1:0] pend_n;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (state != IDLE),
        .zero       (timer_zero)
    );

    // Next-state logic. Clear discards the queue before the GAP exit looks at
    // it, so a cleared queue cannot launch another pulse.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_n     = state;
        timer_load  = 1'b0;
        timer_value = HIGH_LOAD;
        done_n      = 1'b0;
        do_inc      = 1'b0;
        do_dec      = 1'b0;
        pend_avail  = (Pending_Count != '0) && !Clear;

        case (state)
            IDLE: begin
                if (Trigger) begin
                    state_n    = HIGH;
                    timer_load = 1'b1;
                end
            end
            HIGH: begin
                do_inc = Trigger;
                if (timer_zero) begin
                    state_n     = GAP;
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                    done_n      = 1'b1;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    if (pend_avail) begin
                        // Replay a queued request; a same-edge Trigger takes
                        // its place in the queue.
                        state_n    = HIGH;
                        timer_load = 1'b1;
                        do_dec     = 1'b1;
                        do_inc     = Trigger;
                    end else if (Trigger) begin
                        // Empty queue: the Trigger launches directly.
                        state_n    = HIGH;
                        timer_load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    do_inc = Trigger;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Saturating pending counter. Clear wins over everything; an increment
    // paired with a decrement is a no-op and therefore never overflows.
    always_comb begin
        pend_n = Pending_Count;
        ovf_n  = 1'b0;
        if (Clear) begin
            pend_n = '0;
        end else if (do_dec && !do_inc) begin
            pend_n = Pending_Count - PW'(1);
        end else if (do_inc && !do_dec) begin
            if (Pending_Count == PEND_MAX) begin
                ovf_n = 1'b1;
            end else begin
                pend_n = Pending_Count + PW'(1);
            end
        end
    end

    // Outputs are derived from the next state so they line up with it.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            Level_Out     <= 1'b0;
            Done_Pulse    <= 1'b0;
            Busy          <= 1'b0;
            Pending_Count <= '0;
            Overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            Level_Out     <= (state_n == HIGH);
            Done_Pulse    <= done_n;
            Busy          <= (state_n != IDLE);
            Pending_Count <= pend_n;
            Overflow      <= ovf_n;
        end
    end

endmodule

// File: tb/tb_falling_edge_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_falling_edge_pulse_gen
// Self-checking bench. The reference model tracks remaining high/low cycles
// and a queue depth as plain integers and is stepped on every rising edge.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_falling_edge_pulse_gen;

    localparam int H    = 4;
    localparam int L    = 2;
    localparam int MAXP = 3;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic       Trigger = 1'b0;
    logic       Clear = 1'b0;
    logic       Level_Out;
    logic       Done_Pulse;
    logic       Busy;
    logic [1:0] Pending_Count;
    logic       Overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    falling_edge_pulse_gen #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .MAX_PENDING (MAXP)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .Trigger       (Trigger),
        .Clear         (Clear),
        .Level_Out     (Level_Out),
        .Done_Pulse    (Done_Pulse),
        .Busy          (Busy),
        .Pending_Count (Pending_Count),
        .Overflow      (Overflow)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- reference model ----------------
    // hr: high cycles still to show (including the current one)
    // gr: low-gap cycles still to show; pend: queued requests
    typedef struct packed {
        int   hr;
        int   gr;
        int   pend;
        logic done;
        logic ovf;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(model_t s, logic rst_n, logic trig, logic clr);
        model_t n;
        int     pe;
        int     p;
        logic   enq;
        logic   deq;
        n      = s;
        n.done = 1'b0;
        n.ovf  = 1'b0;
        enq    = 1'b0;
        deq    = 1'b0;
        if (!rst_n) begin
            n.hr   = 0;
            n.gr   = 0;
            n.pend = 0;
            return n;
        end
        pe = clr ? 0 : s.pend;
        if (s.hr > 0) begin
            n.hr = s.hr - 1;
            if (n.hr == 0) begin
                n.gr   = L;
                n.done = 1'b1;
            end
            enq = trig;
        end else if (s.gr > 0) begin
            n.gr = s.gr - 1;
            if (n.gr == 0) begin
                if (pe > 0) begin
                    n.hr = H;
                    deq  = 1'b1;
                    enq  = trig;
                end else if (trig) begin
                    n.hr = H;
                end
            end else begin
                enq = trig;
            end
        end else if (trig) begin
            n.hr = H;
        end
        if (clr) begin
            n.pend = 0;
        end else begin
            p = s.pend - (deq ? 1 : 0);
            if (enq) begin
                if (p >= MAXP) n.ovf = 1'b1;
                else p = p + 1;
            end
            n.pend = p;
        end
        return n;
    endfunction

    always @(posedge ACLK) m <= model_step(m, ARESETN, Trigger, Clear);

    function automatic logic [5:0] exp_vec();
        return {(m.hr > 0), m.done, ((m.hr > 0) || (m.gr > 0)), m.ovf, 2'(m.pend)};
    endfunction

    function automatic logic [5:0] obs();
        return {Level_Out, Done_Pulse, Busy, Overflow, Pending_Count};
    endfunction

    // Drive inputs for one rising edge, return at the following falling edge.
    task automatic tick(input logic t, input logic c);
        Trigger = t;
        Clear   = c;
        @(posedge ACLK);
        @(negedge ACLK);
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs(), 6'b0);
        end
        ARESETN = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release cyc %0d: got %b want %b", cyc, obs(), exp_vec());
        end
    endtask

    task automatic test_single();
        int highs = 0;
        int dones = 0;
        int busys = 0;
        int pmax  = 0;
        for (int i = 0; i < 11; i++) begin
            tick(i == 2, 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL single cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            highs += int'(Level_Out);
            dones += int'(Done_Pulse);
            busys += int'(Busy);
            if (int'(Pending_Count) > pmax) pmax = int'(Pending_Count);
            if (i == 2) begin
                checks++;
                if (Level_Out !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency: Level_Out=%b want 1", Level_Out);
                end
            end
            if (i == 6) begin
                checks++;
                if ({Level_Out, Done_Pulse} !== 2'b01) begin
                    errors++;
                    $display("FAIL single_fall: level/done=%b want 01", {Level_Out, Done_Pulse});
                end
            end
            if (i == 8) begin
                checks++;
                if (Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_end: Busy=%b want 0", Busy);
                end
            end
        end
        checks++;
        if (highs != H || dones != 1 || busys != H + L || pmax != 0) begin
            errors++;
            $display("FAIL single_totals: high=%0d done=%0d busy=%0d pend=%0d want %0d 1 %0d 0",
                     highs, dones, busys, pmax, H, H + L);
        end
    endtask

    task automatic test_queue();
        int   falls = 0;
        int   dones = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick((i == 0) || (i == 2) || (i == 3), 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL queue cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            checks++;
            if (Level_Out !== ((i < 16) && ((i % 6) < 4))) begin
                errors++;
                $display("FAIL queue_level i=%0d: got %b want %b", i, Level_Out,
                         ((i < 16) && ((i % 6) < 4)));
            end
            if (i == 3) begin
                checks++;
                if (Pending_Count !== 2'd2) begin
                    errors++;
                    $display("FAIL queue_depth: got %0d want 2", Pending_Count);
                end
            end
            if (prev && !Level_Out) falls++;
            prev = Level_Out;
            dones += int'(Done_Pulse);
        end
        checks++;
        if (falls != 3 || dones != 3) begin
            errors++;
            $display("FAIL queue_totals: falls=%0d dones=%0d want 3 3", falls, dones);
        end
    endtask

    task automatic test_saturation();
        int   falls = 0;
        int   ovfs  = 0;
        int   pmax  = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick(i < 6, 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL sat cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            if (prev && !Level_Out) falls++;
            prev = Level_Out;
            ovfs += int'(Overflow);
            if (int'(Pending_Count) > pmax) pmax = int'(Pending_Count);
        end
        checks++;
        if (falls != 4 || ovfs != 2 || pmax != MAXP) begin
            errors++;
            $display("FAIL sat_totals: falls=%0d ovf=%0d pmax=%0d want 4 2 %0d", falls, ovfs, pmax, MAXP);
        end
    endtask

    task automatic test_gap_retrigger();
        int busys = 0;
        for (int i = 0; i < 15; i++) begin
            tick((i == 0) || (i == 6), 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL gap_retrig cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            if (i <= 6) busys += int'(Busy);
            if (i == 6) begin
                checks++;
                if ({Level_Out, Pending_Count} !== 3'b100) begin
                    errors++;
                    $display("FAIL gap_retrig_rise: level/pend=%b want 100", {Level_Out, Pending_Count});
                end
            end
        end
        checks++;
        if (busys != 7) begin
            errors++;
            $display("FAIL gap_retrig_busy: busy cycles=%0d want 7", busys);
        end
    endtask

    task automatic test_clear();
        int   falls = 0;
        int   dones = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(i < 4, i == 3);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL clear cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (Pending_Count !== ((i == 2) ? 2'd2 : 2'd0)) begin
                    errors++;
                    $display("FAIL clear_depth i=%0d: got %0d want %0d", i, Pending_Count, (i == 2) ? 2 : 0);
                end
            end
            if (prev && !Level_Out) falls++;
            prev = Level_Out;
            dones += int'(Done_Pulse);
        end
        checks++;
        if (falls != 1 || dones != 1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_totals: falls=%0d dones=%0d busy=%b want 1 1 0", falls, dones, Busy);
        end
    endtask

    task automatic test_reset_mid();
        int highs = 0;
        int dones = 0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        ARESETN = 1'b0;
        tick(1'b0, 1'b0);
        checks++;
        if (obs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b want %b", obs(), 6'b0);
        end
        ARESETN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(i == 2, 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
            highs += int'(Level_Out);
            dones += int'(Done_Pulse);
        end
        checks++;
        if (highs != H || dones != 1) begin
            errors++;
            $display("FAIL reset_mid_pulse: high=%0d done=%0d want %0d 1", highs, dones, H);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ARESETN = ($urandom_range(99) != 0);
            tick($urandom_range(9) < 4, $urandom_range(19) == 0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", cyc, obs(), exp_vec());
            end
        end
        ARESETN = 1'b1;
    endtask

    initial begin
        @(negedge ACLK);
        test_reset();
        test_single();
        test_queue();
        test_saturation();
        test_gap_retrigger();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
